// File: rtl/isa_pkg.sv
// Instruction-set constants shared by the instruction memory, fetch and execute stages.
package isa_pkg;

    localparam int OPC_W   = 5;
    localparam int ADDR_W  = 12;
    localparam int INSTR_W = OPC_W + ADDR_W;

    typedef enum logic [OPC_W-1:0] {
        OP_LDAC   = 5'd3,
        OP_LDIAC  = 5'd5,
        OP_STAC   = 5'd8,
        OP_MVAC   = 5'd9,
        OP_MVACAR = 5'd10,
        OP_MVACR1 = 5'd11,
        OP_MVACR2 = 5'd12,
        OP_MVACR3 = 5'd13,
        OP_MVACR4 = 5'd14,
        OP_MVR1AC = 5'd15,
        OP_MVR2AC = 5'd16,
        OP_MVR3AC = 5'd17,
        OP_MVR4AC = 5'd18,
        OP_ADD    = 5'd19,
        OP_MULT   = 5'd20,
        OP_LSHIFT = 5'd21,
        OP_SUB    = 5'd22,
        OP_INAC   = 5'd23,
        OP_JPNZ   = 5'd24,
        OP_JMPZ   = 5'd26,
        OP_NOP    = 5'd28,
        OP_ENDOP  = 5'd31
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_ISSUE,
        ST_HALT
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Memory-read and instruction-issue signals between fetch, instruction memory and execute.
interface fetch_unit_if
    import isa_pkg::*;
#(
    parameter int ADDR_W  = isa_pkg::ADDR_W,
    parameter int INSTR_W = isa_pkg::INSTR_W
);
    logic [ADDR_W-1:0]  pc_addr;
    logic [INSTR_W-1:0] instr_in;
    logic               ir_valid;
    logic [OPC_W-1:0]   ir_opcode;
    logic [ADDR_W-1:0]  ir_operand;
    logic               ir_ready;
    logic               z_flag;

    modport master (
        output pc_addr, ir_valid, ir_opcode, ir_operand,
        input  instr_in, ir_ready, z_flag
    );

    modport slave (
        input  pc_addr, ir_valid, ir_opcode, ir_operand,
        output instr_in, ir_ready, z_flag
    );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, absorbs the one-cycle memory latency and issues one
// instruction at a time to execute, resolving jpnz/jmpz and halting on endop.
module fetch_unit
    import isa_pkg::*;
#(
    parameter int              ADDR_W   = 12,
    parameter int              INSTR_W  = 17,
    parameter logic [ADDR_W-1:0] START_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    fetch_unit_if.master     bus,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    fetch_state_e       state_reg, state_next;
    logic [ADDR_W-1:0]  pc_reg, pc_next;
    logic [INSTR_W-1:0] ir_reg, ir_next;
    logic [CNT_W-1:0]   retired_reg, retired_next;

    logic [OPC_W-1:0]   ir_opc;
    logic [ADDR_W-1:0]  ir_opd;
    logic               xfer;

    assign ir_opc = ir_reg[INSTR_W-1:ADDR_W];
    assign ir_opd = ir_reg[ADDR_W-1:0];
    assign xfer   = (state_reg == ST_ISSUE) && bus.ir_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            pc_reg      <= START_PC;
            ir_reg      <= '0;
            retired_reg <= '0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            ir_reg      <= ir_next;
            retired_reg <= retired_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        ir_next      = ir_reg;
        retired_next = retired_reg;

        case (state_reg)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    pc_next      = START_PC;
                    retired_next = '0;
                    state_next   = ST_FETCH;
                end
            end
            ST_FETCH: state_next = ST_LATCH;
            ST_LATCH: begin
                // Memory data for the address presented during FETCH is valid now.
                ir_next    = bus.instr_in;
                state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (xfer) begin
                    if (retired_reg != '1)
                        retired_next = retired_reg + CNT_W'(1);
                    state_next = ST_FETCH;
                    pc_next    = pc_reg + ADDR_W'(1);
                    case (ir_opc)
                        OP_ENDOP: begin
                            pc_next    = pc_reg;
                            state_next = ST_HALT;
                        end
                        OP_JPNZ: if (!bus.z_flag) pc_next = ir_opd;
                        OP_JMPZ: if (bus.z_flag)  pc_next = ir_opd;
                        default: ;
                    endcase
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs decode straight from registers; no input reaches an output combinationally.
    assign bus.pc_addr    = pc_reg;
    assign bus.ir_valid   = (state_reg == ST_ISSUE);
    assign bus.ir_opcode  = ir_opc;
    assign bus.ir_operand = ir_opd;
    assign busy           = (state_reg == ST_FETCH) || (state_reg == ST_LATCH) ||
                            (state_reg == ST_ISSUE);
    assign halted         = (state_reg == ST_HALT);
    assign retired        = retired_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: a driver queues expected transfers, a
// negedge monitor checks every accepted instruction against the queue.
module tb_fetch_unit;
    import isa_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        halted;
    logic [15:0] retired;

    fetch_unit_if bus ();

    fetch_unit #(
        .ADDR_W   (12),
        .INSTR_W  (17),
        .START_PC (12'd0),
        .CNT_W    (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bus     (bus),
        .busy    (busy),
        .halted  (halted),
        .retired (retired)
    );

    int vectors     = 0;
    int miscompares = 0;
    int exp_ret     = 0;

    logic [16:0] mem [0:4095];
    logic [28:0] exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bus.instr_in <= mem[bus.pc_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one check set per accepted transfer.
    always @(negedge clk) begin
        if (!rst && bus.ir_valid && bus.ir_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_xfer", 32'(exp_q.size()), 32'd1);
            end else begin
                logic [28:0] e;
                e = exp_q.pop_front();
                check("xfer_pc", 32'(bus.pc_addr), 32'(e[28:17]));
                check("xfer_instr", 32'({bus.ir_opcode, bus.ir_operand}), 32'(e[16:0]));
                $display("xfer pc=%0d opcode=%0d operand=%0d z=%0b", bus.pc_addr,
                         bus.ir_opcode, bus.ir_operand, bus.z_flag);
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        exp_ret = 0;
        check("start_pc", 32'(bus.pc_addr), 32'd0);
        check("start_busy", 32'(busy), 32'd1);
        check("start_halted", 32'(halted), 32'd0);
        check("start_retired", 32'(retired), 32'd0);
        check("start_valid_c1", 32'(bus.ir_valid), 32'd0);
        @(posedge clk); #1;
        check("start_valid_c2", 32'(bus.ir_valid), 32'd0);
        @(posedge clk); #1;
        check("start_valid_c3", 32'(bus.ir_valid), 32'd1);
    endtask

    // Wait for issue, optionally stall (with a stray start pulse), then accept.
    task automatic xfer(input logic [11:0] pc, input logic [4:0] op, input logic [11:0] opd,
                        input logic z, input int stall);
        int          n;
        logic [11:0] pc0;
        logic [16:0] ir0;
        n = 0;
        exp_q.push_back({pc, op, opd});
        while (!bus.ir_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("issue_seen", 32'(bus.ir_valid), 32'd1);
        pc0 = bus.pc_addr;
        ir0 = {bus.ir_opcode, bus.ir_operand};
        for (int i = 0; i < stall; i++) begin
            if (i == 1) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            check("stall_valid", 32'(bus.ir_valid), 32'd1);
            check("stall_pc", 32'(bus.pc_addr), 32'(pc0));
            check("stall_ir", 32'({bus.ir_opcode, bus.ir_operand}), 32'(ir0));
        end
        bus.z_flag   = z;
        bus.ir_ready = 1'b1;
        @(posedge clk); #1;
        bus.ir_ready = 1'b0;
        exp_ret++;
        check("retired", 32'(retired), 32'(exp_ret));
        check("valid_drop", 32'(bus.ir_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = '0;
        mem[0]    = {OP_LDIAC, 12'd4095};
        mem[1]    = {OP_ADD,   12'd3};
        mem[2]    = {OP_JPNZ,  12'd29};
        mem[3]    = {OP_JPNZ,  12'd4095};
        mem[10]   = {OP_JMPZ,  12'd49};
        mem[11]   = {OP_SUB,   12'd1};
        mem[12]   = {OP_JPNZ,  12'd57};
        mem[29]   = {OP_JPNZ,  12'd0};
        mem[30]   = {OP_JMPZ,  12'd10};
        mem[49]   = {OP_JPNZ,  12'd10};
        mem[57]   = {OP_ENDOP, 12'd0};
        mem[4095] = {OP_NOP,   12'd0};

        rst          = 1'b1;
        start        = 1'b0;
        bus.ir_ready = 1'b0;
        bus.z_flag   = 1'b0;
        #12;
        check("rst_pc", 32'(bus.pc_addr), 32'd0);
        check("rst_valid", 32'(bus.ir_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        check("rst_ir", 32'({bus.ir_opcode, bus.ir_operand}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 32'd0);

        do_start();
        xfer(12'd0,  OP_LDIAC, 12'd4095, 1'b0, 4);
        check("post_backpressure_pc", 32'(bus.pc_addr), 32'd1);
        xfer(12'd1,  OP_ADD,   12'd3,  1'b0, 0);
        xfer(12'd2,  OP_JPNZ,  12'd29, 1'b0, 0);
        xfer(12'd29, OP_JPNZ,  12'd0,  1'b0, 0);
        xfer(12'd0,  OP_LDIAC, 12'd4095, 1'b0, 0);
        xfer(12'd1,  OP_ADD,   12'd3,  1'b0, 0);
        xfer(12'd2,  OP_JPNZ,  12'd29, 1'b0, 0);
        xfer(12'd29, OP_JPNZ,  12'd0,  1'b1, 0);
        xfer(12'd30, OP_JMPZ,  12'd10, 1'b1, 0);
        xfer(12'd10, OP_JMPZ,  12'd49, 1'b1, 2);
        xfer(12'd49, OP_JPNZ,  12'd10, 1'b0, 0);
        xfer(12'd10, OP_JMPZ,  12'd49, 1'b0, 0);
        xfer(12'd11, OP_SUB,   12'd1,  1'b1, 0);
        xfer(12'd12, OP_JPNZ,  12'd57, 1'b0, 0);
        xfer(12'd57, OP_ENDOP, 12'd0,  1'b0, 0);
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_busy", 32'(busy), 32'd0);
        check("halt_retired", 32'(retired), 32'd15);
        repeat (3) @(posedge clk);
        #1;
        check("halt_pc_held", 32'(bus.pc_addr), 32'd57);
        check("halt_still", 32'(halted), 32'd1);
        check("halt_no_fetch", 32'(busy), 32'd0);

        do_start();
        check("restart_halted", 32'(halted), 32'd0);
        xfer(12'd0,    OP_LDIAC, 12'd4095, 1'b0, 0);
        xfer(12'd1,    OP_ADD,   12'd3,    1'b0, 0);
        xfer(12'd2,    OP_JPNZ,  12'd29,   1'b1, 0);
        xfer(12'd3,    OP_JPNZ,  12'd4095, 1'b0, 0);
        xfer(12'd4095, OP_NOP,   12'd0,    1'b0, 0);
        check("wrap_pc", 32'(bus.pc_addr), 32'd0);

        for (int n = 0; n < 10 && !bus.ir_valid; n++) begin
            @(posedge clk); #1;
        end
        check("pre_rst_valid", 32'(bus.ir_valid), 32'd1);
        check("pre_rst_retired", 32'(retired), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(bus.ir_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_halted", 32'(halted), 32'd0);
        check("arst_retired", 32'(retired), 32'd0);
        check("arst_ir", 32'({bus.ir_opcode, bus.ir_operand}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_idle", 32'(busy), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly downstream of the instruction memory and upstream of the execute/datapath controller. It owns the program counter, presents read addresses to the synchronous-read instruction memory, and absorbs its one-cycle read latency. It latches each 17-bit instruction into an instruction register split into opcode/operand fields and hands it to execute over a valid/ready handshake. It resolves `jpnz`/`jmpz` redirects and stops fetching on `endop`.

## Interface
- `ADDR_W`, 12, PC / memory address width; also the operand width.
- `INSTR_W`, 17, instruction width: `{opcode[4:0], operand[ADDR_W-1:0]}`.
- `START_PC`, 0, PC loaded on `start`.
- `CNT_W`, 16, width of the retired-instruction counter.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; honoured only in IDLE or HALT.
- `pc_addr`  out  ADDR_W  registered read address to the instruction memory.
- `instr_in`  in  INSTR_W  instruction memory read data, valid the cycle after `pc_addr` is sampled.
- `ir_valid`  out  1  IR holds an instruction for execute.
- `ir_opcode`  out  5  `IR[INSTR_W-1:ADDR_W]`.
- `ir_operand`  out  ADDR_W  `IR[ADDR_W-1:0]`.
- `ir_ready`  in  1  execute accepts the IR; a transfer occurs when `ir_valid && ir_ready`.
- `z_flag`  in  1  accumulator-zero flag from the datapath; sampled only on transfer of `jpnz`/`jmpz`.
- `busy`  out  1  high in FETCH, LATCH and ISSUE.
- `halted`  out  1  high in HALT.
- `retired`  out  CNT_W  count of transfers since the last `start`; saturates at all-ones.

## Operation
- States:
  - IDLE: wait for `start`.
  - FETCH: `pc_addr` stable; memory samples it.
  - LATCH: `instr_in` valid; captured into IR at the end of the cycle.
  - ISSUE: `ir_valid=1`; wait for a transfer.
  - HALT: wait for `start`.
- Transitions:
  - IDLE or HALT, on `start`: `pc_addr <= START_PC`, `retired <= 0`, `halted <= 0`, go to FETCH.
  - FETCH → LATCH, unconditionally.
  - LATCH → ISSUE, unconditionally.
  - ISSUE without a transfer: stay. IR, `pc_addr` and `ir_valid` are held.
  - ISSUE with a transfer: increment `retired`, then act on the opcode:
    - opcode 31 (`endop`): go to HALT. `pc_addr` is held.
    - opcode 24 (`jpnz`): if `z_flag==0`, `pc_addr <= operand`; else `pc_addr <= pc_addr+1`. Go to FETCH.
    - opcode 26 (`jmpz`): if `z_flag==1`, `pc_addr <= operand`; else `pc_addr <= pc_addr+1`. Go to FETCH.
    - any other opcode, including unassigned codes: `pc_addr <= pc_addr+1`. Go to FETCH.
- No decode or legality checking beyond the three control opcodes; unknown opcodes are issued unchanged.
- PC arithmetic is modulo 2^ADDR_W: 4095+1 wraps to 0.
- `start` outside IDLE/HALT is ignored.
- Only one instruction is in flight, so `z_flag` at transfer always reflects every earlier instruction.
- Reset values:
  - state IDLE;
  - `pc_addr=START_PC`;
  - IR=0, so `ir_opcode=0` and `ir_operand=0`;
  - `ir_valid=0`, `busy=0`, `halted=0`, `retired=0`.
- Reset mid-operation: all outputs take their reset values asynchronously, with no clock edge required. Any instruction in flight is discarded.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Start-to-issue: `start` sampled at edge 0 → FETCH in cycle 1 → LATCH in cycle 2 → `ir_valid` high in cycle 3.
- Transfer-to-next-issue: a transfer at edge N puts the new `pc_addr` in FETCH during cycle N+1. The next `ir_valid` rises at cycle N+3. Throughput is one instruction per 3 cycles with `ir_ready` tied high.
- `ir_valid` drops in the cycle after a transfer.
- On `endop` transfer, `halted` rises in the cycle after the transfer.

## Structure
- Shared package `isa_pkg`:
  - 5-bit opcode constants: ldac=3, ldiac=5, stac=8, mvac=9, mvacar=10, mvacr1..4=11..14, mvr1..4ac=15..18, add=19, mult=20, lshift=21, sub=22, inac=23, jpnz=24, jmpz=26, nop=28, endop=31.
  - Field-width constants: OPC_W=5, ADDR_W=12, INSTR_W=17.
  - Also used by the instruction memory and execute.
- No sub-module is needed. It is a single FSM with its PC, IR and counter registers.

## Test plan
1. Reset release with mem[0]={5'd5,12'd4095} and `ir_ready=1`; pulse `start` → `pc_addr=0` in cycle 1; in cycle 3 `ir_valid=1`, `ir_opcode=5`, `ir_operand=4095`; `busy=1`.
2. Backpressure: `ir_ready=0` for 4 cycles in ISSUE → `ir_valid`, IR and `pc_addr` are stable. Raising `ir_ready` → next FETCH at `pc_addr=1`; `retired=1`.
3. `jpnz` {24,0} at address 29 → with `z_flag=0` the next `pc_addr=0`; repeated with `z_flag=1` the next `pc_addr=30`.
4. `jmpz` {26,49} at address 10 → with `z_flag=1` the next `pc_addr=49`; with `z_flag=0` the next `pc_addr=11`.
5. `endop` at address 57 accepted → `halted=1` the following cycle, no further FETCH, `busy=0`. A second `start` → `retired=0` and fetch from `START_PC`.
6. Assert `rst` asynchronously mid-ISSUE, between clock edges → `ir_valid`, `busy`, `halted` and `retired` read 0 immediately. Separately, a non-branch instruction at address 4095 → next `pc_addr=0`.
